control_sequencer: RTL and testbench

Hardwired Moore control unit that generates, cycle by cycle, the control strobes the datapath consumes for fetch and execute. It replaces hand-scripted bench stimulus: it reads the opcode from IR and steps through T-states. It sits beside the datapath, and its outputs connect one-to-one to the same-named datapath inputs. The ALU derives its operation from IR itself: add for ld/ldi/st/addi and for the T0 PC increment.

---
 rtl/control_sequencer_if.sv | 33 +++
 rtl/control_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Strobe bundle between the control sequencer (master) and the datapath (slave).
// The opcode flows from the datapath's IR to the sequencer; every strobe flows back.
interface control_sequencer_if #(
    parameter int OPCODE_W = 5
);
    logic [OPCODE_W-1:0] opcode;

    logic pc_out, zlo_out, mdr_out, hi_out, lo_out, inport_out, ba_out, r_out;
    logic c_sign_extended_out;
    logic mar_enable, pc_enable, pc_increment, mdr_enable, ir_enable;
    logic y_enable, z_enable, outport_enable;
    logic r_in, gra, grb, grc;
    logic read, ram_write;
    logic run, illegal;

    // There is no handshake: every strobe is a level, valid for exactly the
    // clock cycle in which it is high, and the datapath acts on it at that edge.
    modport master (
        input  opcode,
        output pc_out, zlo_out, mdr_out, hi_out, lo_out, inport_out, ba_out, r_out,
               c_sign_extended_out, mar_enable, pc_enable, pc_increment, mdr_enable,
               ir_enable, y_enable, z_enable, outport_enable, r_in, gra, grb, grc,
               read, ram_write, run, illegal
    );

    modport slave (
        output opcode,
        input  pc_out, zlo_out, mdr_out, hi_out, lo_out, inport_out, ba_out, r_out,
               c_sign_extended_out, mar_enable, pc_enable, pc_increment, mdr_enable,
               ir_enable, y_enable, z_enable, outport_enable, r_in, gra, grb, grc,
               read, ram_write, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore T-state sequencer driving the datapath strobes for fetch/execute.
// Optional ILLEGAL_TRAP_EN: unknown opcodes halt and raise a sticky illegal flag.
module control_sequencer #(
    parameter int OPCODE_W = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus,
    output logic [3:0]          state_dbg
);

    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_T7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(5'b00000);
    localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(5'b00001);
    localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(5'b00010);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(5'b00011);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(5'b00100);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5'b00101);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(5'b00110);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5'b01100);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(5'b01101);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(5'b01110);
    localparam logic [OPCODE_W-1:0] OP_IN   = OPCODE_W'(5'b10110);
    localparam logic [OPCODE_W-1:0] OP_OUT  = OPCODE_W'(5'b10111);
    localparam logic [OPCODE_W-1:0] OP_MFHI = OPCODE_W'(5'b11000);
    localparam logic [OPCODE_W-1:0] OP_MFLO = OPCODE_W'(5'b11001);
    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(5'b11010);
    localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(5'b11011);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    logic [3:0] state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       illegal_d;

    logic is_ld, is_ldi, is_st, is_imm, is_alu, is_short, is_nop, is_halt, is_known;
    logic is_mem_addr;

    assign is_ld       = (bus.opcode == OP_LD);
    assign is_ldi      = (bus.opcode == OP_LDI);
    assign is_st       = (bus.opcode == OP_ST);
    assign is_imm      = is_ldi || (bus.opcode == OP_ADDI) || (bus.opcode == OP_ANDI) ||
                         (bus.opcode == OP_ORI);
    assign is_alu      = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                         (bus.opcode == OP_AND) || (bus.opcode == OP_OR);
    assign is_short    = (bus.opcode == OP_MFHI) || (bus.opcode == OP_MFLO) ||
                         (bus.opcode == OP_IN) || (bus.opcode == OP_OUT);
    assign is_nop      = (bus.opcode == OP_NOP);
    assign is_halt     = (bus.opcode == OP_HALT);
    assign is_known    = is_ld || is_st || is_imm || is_alu || is_short || is_nop || is_halt;
    // ld/st/ldi form base+offset addresses; ba_out reads R0 as zero.
    assign is_mem_addr = is_ld || is_st || is_ldi;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0: begin
                state_d = ST_T1;
                wait_d  = WAIT_INIT;
            end
            ST_T1: begin
                if (wait_q == 3'd0) state_d = ST_T2;
                else                wait_d  = wait_q - 3'd1;
            end
            ST_T2: begin
`ifdef ILLEGAL_TRAP_EN
                if (is_halt)     state_d = ST_HALT;
                else if (is_nop) state_d = ST_T0;
                else             state_d = ST_T3;
`else
                if (is_halt)                   state_d = ST_HALT;
                else if (is_nop || !is_known)  state_d = ST_T0;
                else                           state_d = ST_T3;
`endif
            end
            ST_T3: begin
                if (is_imm || is_alu || is_ld || is_st) state_d = ST_T4;
                else if (is_short)                      state_d = ST_T0;
                else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_T4: state_d = ST_T5;
            ST_T5: begin
                if (is_ld || is_st) state_d = ST_T6;
                else                state_d = ST_T0;
                wait_d = WAIT_INIT;
            end
            ST_T6: begin
                if (is_st) begin
                    state_d = ST_T7;
                    wait_d  = WAIT_INIT;
                end else if (wait_q == 3'd0) begin
                    state_d = ST_T7;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ST_T7: begin
                if (!is_st || wait_q == 3'd0) state_d = ST_T0;
                else                          wait_d  = wait_q - 3'd1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_RST;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (!clr) illegal_q <= 1'b0;
        else      illegal_q <= illegal_q | illegal_d;
    end
    assign bus.illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_d;
    assign bus.illegal    = 1'b0;
`endif

    assign state_dbg = state_q;
    assign bus.run   = (state_q != ST_RST) && (state_q != ST_HALT);

    always_comb begin
        bus.pc_out = 1'b0;  bus.zlo_out = 1'b0;  bus.mdr_out = 1'b0;  bus.hi_out = 1'b0;
        bus.lo_out = 1'b0;  bus.inport_out = 1'b0;  bus.ba_out = 1'b0;  bus.r_out = 1'b0;
        bus.c_sign_extended_out = 1'b0;
        bus.mar_enable = 1'b0;  bus.pc_enable = 1'b0;  bus.pc_increment = 1'b0;
        bus.mdr_enable = 1'b0;  bus.ir_enable = 1'b0;  bus.y_enable = 1'b0;
        bus.z_enable = 1'b0;  bus.outport_enable = 1'b0;
        bus.r_in = 1'b0;  bus.gra = 1'b0;  bus.grb = 1'b0;  bus.grc = 1'b0;
        bus.read = 1'b0;  bus.ram_write = 1'b0;
        case (state_q)
            ST_T0: begin
                bus.pc_out = 1'b1;  bus.mar_enable = 1'b1;
                bus.pc_increment = 1'b1;  bus.z_enable = 1'b1;
            end
            ST_T1: begin
                bus.zlo_out = 1'b1;  bus.read = 1'b1;  bus.mdr_enable = 1'b1;
                // Load PC only on the last wait cycle so one fetch moves PC once.
                bus.pc_enable = (wait_q == 3'd0);
            end
            ST_T2: begin
                bus.mdr_out = 1'b1;  bus.ir_enable = 1'b1;
            end
            ST_T3: begin
                if (is_imm || is_alu || is_ld || is_st) begin
                    bus.grb      = 1'b1;
                    bus.y_enable = 1'b1;
                    bus.ba_out   = is_mem_addr;
                    bus.r_out    = !is_mem_addr;
                end else if (bus.opcode == OP_MFHI) begin
                    bus.hi_out = 1'b1;  bus.gra = 1'b1;  bus.r_in = 1'b1;
                end else if (bus.opcode == OP_MFLO) begin
                    bus.lo_out = 1'b1;  bus.gra = 1'b1;  bus.r_in = 1'b1;
                end else if (bus.opcode == OP_IN) begin
                    bus.inport_out = 1'b1;  bus.gra = 1'b1;  bus.r_in = 1'b1;
                end else if (bus.opcode == OP_OUT) begin
                    bus.gra = 1'b1;  bus.r_out = 1'b1;  bus.outport_enable = 1'b1;
                end
            end
            ST_T4: begin
                bus.z_enable = 1'b1;
                if (is_alu) begin
                    bus.grc = 1'b1;  bus.r_out = 1'b1;
                end else begin
                    bus.c_sign_extended_out = 1'b1;
                end
            end
            ST_T5: begin
                bus.zlo_out = 1'b1;
                if (is_ld || is_st) bus.mar_enable = 1'b1;
                else begin
                    bus.gra = 1'b1;  bus.r_in = 1'b1;
                end
            end
            ST_T6: begin
                bus.mdr_enable = 1'b1;
                if (is_st) begin
                    bus.gra = 1'b1;  bus.r_out = 1'b1;
                end else begin
                    bus.read = 1'b1;
                end
            end
            ST_T7: begin
                if (is_st) bus.ram_write = 1'b1;
                else begin
                    bus.mdr_out = 1'b1;  bus.gra = 1'b1;  bus.r_in = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: two instances (MEM_WAIT=0 and MEM_WAIT=2)
// compared cycle by cycle against hand-written strobe vectors.
module tb_control_sequencer;

  localparam logic [24:0] M_PC_OUT  = 25'd1 << 0;
  localparam logic [24:0] M_ZLO     = 25'd1 << 1;
  localparam logic [24:0] M_MDR_OUT = 25'd1 << 2;
  localparam logic [24:0] M_HI      = 25'd1 << 3;
  localparam logic [24:0] M_LO      = 25'd1 << 4;
  localparam logic [24:0] M_INPORT  = 25'd1 << 5;
  localparam logic [24:0] M_BA      = 25'd1 << 6;
  localparam logic [24:0] M_R_OUT   = 25'd1 << 7;
  localparam logic [24:0] M_CSE     = 25'd1 << 8;
  localparam logic [24:0] M_MAR     = 25'd1 << 9;
  localparam logic [24:0] M_PC_EN   = 25'd1 << 10;
  localparam logic [24:0] M_PC_INC  = 25'd1 << 11;
  localparam logic [24:0] M_MDR_EN  = 25'd1 << 12;
  localparam logic [24:0] M_IR_EN   = 25'd1 << 13;
  localparam logic [24:0] M_Y       = 25'd1 << 14;
  localparam logic [24:0] M_Z       = 25'd1 << 15;
  localparam logic [24:0] M_OUTP    = 25'd1 << 16;
  localparam logic [24:0] M_R_IN    = 25'd1 << 17;
  localparam logic [24:0] M_GRA     = 25'd1 << 18;
  localparam logic [24:0] M_GRB     = 25'd1 << 19;
  localparam logic [24:0] M_GRC     = 25'd1 << 20;
  localparam logic [24:0] M_READ    = 25'd1 << 21;
  localparam logic [24:0] M_RAM_W   = 25'd1 << 22;
  localparam logic [24:0] M_RUN     = 25'd1 << 23;
  localparam logic [24:0] M_ILL     = 25'd1 << 24;

  localparam logic [24:0] F0  = M_RUN | M_PC_OUT | M_MAR | M_PC_INC | M_Z;
  localparam logic [24:0] F1W = M_RUN | M_ZLO | M_READ | M_MDR_EN;
  localparam logic [24:0] F1  = F1W | M_PC_EN;
  localparam logic [24:0] F2  = M_RUN | M_MDR_OUT | M_IR_EN;

  logic       clk;
  logic       clr;
  logic [4:0] op;
  logic [3:0] state0, state2;
  int         total;
  int         bad;
  logic [24:0] exp_q[$];

  control_sequencer_if #(.OPCODE_W(5)) if0 ();
  control_sequencer_if #(.OPCODE_W(5)) if2 ();
  assign if0.opcode = op;
  assign if2.opcode = op;

  control_sequencer #(.OPCODE_W(5), .MEM_WAIT(0)) dut0 (
    .clk(clk), .clr(clr), .bus(if0), .state_dbg(state0)
  );
  control_sequencer #(.OPCODE_W(5), .MEM_WAIT(2)) dut2 (
    .clk(clk), .clr(clr), .bus(if2), .state_dbg(state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] pack0();
    return {if0.illegal, if0.run, if0.ram_write, if0.read, if0.grc, if0.grb, if0.gra,
            if0.r_in, if0.outport_enable, if0.z_enable, if0.y_enable, if0.ir_enable,
            if0.mdr_enable, if0.pc_increment, if0.pc_enable, if0.mar_enable,
            if0.c_sign_extended_out, if0.r_out, if0.ba_out, if0.inport_out, if0.lo_out,
            if0.hi_out, if0.mdr_out, if0.zlo_out, if0.pc_out};
  endfunction

  function automatic logic [24:0] pack2();
    return {if2.illegal, if2.run, if2.ram_write, if2.read, if2.grc, if2.grb, if2.gra,
            if2.r_in, if2.outport_enable, if2.z_enable, if2.y_enable, if2.ir_enable,
            if2.mdr_enable, if2.pc_increment, if2.pc_enable, if2.mar_enable,
            if2.c_sign_extended_out, if2.r_out, if2.ba_out, if2.inport_out, if2.lo_out,
            if2.hi_out, if2.mdr_out, if2.zlo_out, if2.pc_out};
  endfunction

  // driver: two reset cycles, release so the next edge enters T0
  task automatic apply_reset(input logic [4:0] opcode);
    op  = opcode;
    clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
  endtask

  task automatic test_reset();
    op  = 5'b00001;
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== 25'd0) begin
        bad++;
        $display("FAIL reset0 cyc%0d: got %h want %h", i, pack0(), 25'd0);
      end
      total++;
      if (pack2() !== 25'd0) begin
        bad++;
        $display("FAIL reset2 cyc%0d: got %h want %h", i, pack2(), 25'd0);
      end
    end
    clr = 1'b1;
    @(posedge clk); #1;
    total++;
    if (pack0() !== F0) begin
      bad++;
      $display("FAIL reset_first_t0: got %h want %h", pack0(), F0);
    end
  endtask

  task automatic test_ldi();
    apply_reset(5'b00001);
    exp_q = {F0, F1, F2, M_RUN | M_GRB | M_BA | M_Y, M_RUN | M_CSE | M_Z,
             M_RUN | M_ZLO | M_GRA | M_R_IN, F0, F1};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== exp_q[i]) begin
        bad++;
        $display("FAIL ldi step%0d: got %h want %h", i, pack0(), exp_q[i]);
      end
    end
  endtask

  task automatic test_add();
    apply_reset(5'b00011);
    exp_q = {F0, F1, F2, M_RUN | M_GRB | M_R_OUT | M_Y, M_RUN | M_GRC | M_R_OUT | M_Z,
             M_RUN | M_ZLO | M_GRA | M_R_IN, F0};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== exp_q[i]) begin
        bad++;
        $display("FAIL add step%0d: got %h want %h", i, pack0(), exp_q[i]);
      end
    end
  endtask

  task automatic test_mflo();
    apply_reset(5'b11001);
    exp_q = {F0, F1, F2, M_RUN | M_LO | M_GRA | M_R_IN, F0, F1, F2,
             M_RUN | M_LO | M_GRA | M_R_IN, F0};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== exp_q[i]) begin
        bad++;
        $display("FAIL mflo step%0d: got %h want %h", i, pack0(), exp_q[i]);
      end
    end
  endtask

  task automatic test_out();
    apply_reset(5'b10111);
    exp_q = {F0, F1, F2, M_RUN | M_GRA | M_R_OUT | M_OUTP, F0};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== exp_q[i]) begin
        bad++;
        $display("FAIL out step%0d: got %h want %h", i, pack0(), exp_q[i]);
      end
    end
  endtask

  task automatic test_ld();
    apply_reset(5'b00000);
    exp_q = {F0, F1, F2, M_RUN | M_GRB | M_BA | M_Y, M_RUN | M_CSE | M_Z,
             M_RUN | M_ZLO | M_MAR, M_RUN | M_READ | M_MDR_EN,
             M_RUN | M_MDR_OUT | M_GRA | M_R_IN, F0};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== exp_q[i]) begin
        bad++;
        $display("FAIL ld step%0d: got %h want %h", i, pack0(), exp_q[i]);
      end
    end
  endtask

  task automatic test_st_wait();
    apply_reset(5'b00010);
    exp_q = {F0, F1W, F1W, F1, F2, M_RUN | M_GRB | M_BA | M_Y, M_RUN | M_CSE | M_Z,
             M_RUN | M_ZLO | M_MAR, M_RUN | M_GRA | M_R_OUT | M_MDR_EN,
             M_RUN | M_RAM_W, M_RUN | M_RAM_W, M_RUN | M_RAM_W, F0};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack2() !== exp_q[i]) begin
        bad++;
        $display("FAIL st_wait step%0d: got %h want %h", i, pack2(), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_st();
    apply_reset(5'b00010);
    // T0, T1 x3, T2, T3, T4, T5, T6, first T7 cycle
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (pack2() !== (M_RUN | M_RAM_W)) begin
      bad++;
      $display("FAIL mid_st_pre: got %h want %h", pack2(), M_RUN | M_RAM_W);
    end
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (pack2() !== 25'd0) begin
        bad++;
        $display("FAIL mid_st_abort cyc%0d: got %h want %h", i, pack2(), 25'd0);
      end
    end
    clr = 1'b1;
    @(posedge clk); #1;
    total++;
    if (pack2() !== F0) begin
      bad++;
      $display("FAIL mid_st_restart: got %h want %h", pack2(), F0);
    end
  endtask

  task automatic test_nop();
    apply_reset(5'b11010);
    exp_q = {F0, F1, F2, F0, F1, F2, F0};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== exp_q[i]) begin
        bad++;
        $display("FAIL nop step%0d: got %h want %h", i, pack0(), exp_q[i]);
      end
    end
  endtask

  task automatic test_halt();
    apply_reset(5'b11011);
    exp_q = {F0, F1, F2, 25'd0, 25'd0, 25'd0, 25'd0};
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== exp_q[i]) begin
        bad++;
        $display("FAIL halt step%0d: got %h want %h", i, pack0(), exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    apply_reset(5'b11111);
`ifdef ILLEGAL_TRAP_EN
    exp_q = {F0, F1, F2, M_RUN, M_ILL, M_ILL, M_ILL, M_ILL};
`else
    exp_q = {F0, F1, F2, F0, F1, F2, F0};
`endif
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      total++;
      if (pack0() !== exp_q[i]) begin
        bad++;
        $display("FAIL illegal step%0d: got %h want %h", i, pack0(), exp_q[i]);
      end
    end
    // flag clears only through clr
    clr = 1'b0;
    @(posedge clk); #1;
    total++;
    if (pack0() !== 25'd0) begin
      bad++;
      $display("FAIL illegal_clear: got %h want %h", pack0(), 25'd0);
    end
    clr = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b0;
    op    = 5'b00000;
    test_reset();
    test_ldi();
    test_add();
    test_mflo();
    test_out();
    test_ld();
    test_st_wait();
    test_reset_mid_st();
    test_nop();
    test_halt();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
